// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: each master's address phase is captured into a pending
// register, then replayed to the shared slave as a single NONSEQ transfer, round-robin with lock.
module ahb_lite_arbiter_2m #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,

    input  logic          M0_HSEL,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [2:0]    M0_HBURST,
    input  logic [3:0]    M0_HPROT,
    input  logic          M0_HMASTLOCK,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    output logic [DW-1:0] M0_HRDATA,
    output logic          M0_HRESP,

    input  logic          M1_HSEL,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [2:0]    M1_HBURST,
    input  logic [3:0]    M1_HPROT,
    input  logic          M1_HMASTLOCK,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic [DW-1:0] M1_HRDATA,
    output logic          M1_HRESP,

    output logic          S_HSEL,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [2:0]    S_HBURST,
    output logic [3:0]    S_HPROT,
    output logic          S_HMASTLOCK,
    output logic [DW-1:0] S_HWDATA,
    output logic          S_HREADY,
    input  logic          S_HREADYOUT,
    input  logic [DW-1:0] S_HRDATA,
    input  logic          S_HRESP
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [2:0]    size;
        logic [3:0]    prot;
        logic          lock;
    } pend_t;

    state_t state_q, state_d;
    pend_t  pend0_q, pend0_d, pend1_q, pend1_d;
    logic   pend0_v_q, pend0_v_d, pend1_v_q, pend1_v_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;
    logic   lock_v_q, lock_v_d;
    logic   lock_owner_q, lock_owner_d;

    pend_t  own_pend;
    logic   in_data, done, cap0, cap1, elig0, elig1, grant, other_v;

    // Burst type and the SEQ/NONSEQ distinction are dropped: every beat becomes NONSEQ SINGLE.
    logic   unused_inputs;
    assign unused_inputs = ^{M0_HBURST, M1_HBURST, M0_HTRANS[0], M1_HTRANS[0]};

    assign own_pend = owner_q ? pend1_q : pend0_q;
    assign in_data  = (state_q == ST_DATA);
    assign done     = in_data & S_HREADYOUT;
    assign other_v  = owner_q ? pend0_v_q : pend1_v_q;

    assign M0_HREADY = ~pend0_v_q | (done & ~owner_q);
    assign M1_HREADY = ~pend1_v_q | (done & owner_q);

    assign cap0  = M0_HSEL & M0_HTRANS[1] & M0_HREADY;
    assign cap1  = M1_HSEL & M1_HTRANS[1] & M1_HREADY;
    assign elig0 = pend0_v_q & (~lock_v_q | ~lock_owner_q);
    assign elig1 = pend1_v_q & (~lock_v_q | lock_owner_q);
    assign grant = (elig0 & elig1) ? ~last_grant_q : elig1;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        lock_v_d     = lock_v_q;
        lock_owner_d = lock_owner_q;
        pend0_d      = pend0_q;
        pend1_d      = pend1_q;
        pend0_v_d    = pend0_v_q;
        pend1_v_d    = pend1_v_q;

        case (state_q)
            ST_IDLE: begin
                if (elig0 | elig1) begin
                    state_d      = ST_ADDR;
                    owner_d      = grant;
                    last_grant_d = grant;
                end
            end
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: begin
                if (S_HREADYOUT) begin
                    lock_v_d     = own_pend.lock;
                    lock_owner_d = owner_q;
                    if (owner_q) pend1_v_d = 1'b0;
                    else         pend0_v_d = 1'b0;
                    // Only the other master is considered here; the owner's same-edge capture waits for IDLE.
                    if (other_v & ~own_pend.lock) begin
                        state_d      = ST_ADDR;
                        owner_d      = ~owner_q;
                        last_grant_d = ~owner_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cap0) begin
            pend0_v_d     = 1'b1;
            pend0_d.addr  = M0_HADDR;
            pend0_d.write = M0_HWRITE;
            pend0_d.size  = M0_HSIZE;
            pend0_d.prot  = M0_HPROT;
            pend0_d.lock  = M0_HMASTLOCK;
        end
        if (cap1) begin
            pend1_v_d     = 1'b1;
            pend1_d.addr  = M1_HADDR;
            pend1_d.write = M1_HWRITE;
            pend1_d.size  = M1_HSIZE;
            pend1_d.prot  = M1_HPROT;
            pend1_d.lock  = M1_HMASTLOCK;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            pend0_q      <= '0;
            pend1_q      <= '0;
            pend0_v_q    <= 1'b0;
            pend1_v_q    <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_v_q     <= 1'b0;
            lock_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend0_q      <= pend0_d;
            pend1_q      <= pend1_d;
            pend0_v_q    <= pend0_v_d;
            pend1_v_q    <= pend1_v_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            lock_v_q     <= lock_v_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    assign S_HSEL      = (state_q == ST_ADDR);
    assign S_HTRANS    = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
    assign S_HADDR     = own_pend.addr;
    assign S_HWRITE    = own_pend.write;
    assign S_HSIZE     = own_pend.size;
    assign S_HPROT     = own_pend.prot;
    assign S_HMASTLOCK = own_pend.lock;
    assign S_HBURST    = '0;
    assign S_HWDATA    = in_data ? (owner_q ? M1_HWDATA : M0_HWDATA) : '0;
    assign S_HREADY    = (state_q == ST_IDLE) ? 1'b1 : S_HREADYOUT;

    assign M0_HRDATA = (in_data & ~owner_q) ? S_HRDATA : '0;
    assign M1_HRDATA = (in_data & owner_q) ? S_HRDATA : '0;
    assign M0_HRESP  = in_data & ~owner_q & S_HRESP;
    assign M1_HRESP  = in_data & owner_q & S_HRESP;

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed bench for ahb_lite_arbiter_2m: inputs change 1 time unit after each rising
// edge, outputs are sampled 4 units after the edge.
module tb_ahb_lite_arbiter_2m;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          M0_HSEL, M1_HSEL;
    logic [AW-1:0] M0_HADDR, M1_HADDR;
    logic [1:0]    M0_HTRANS, M1_HTRANS;
    logic          M0_HWRITE, M1_HWRITE;
    logic [2:0]    M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
    logic [3:0]    M0_HPROT, M1_HPROT;
    logic          M0_HMASTLOCK, M1_HMASTLOCK;
    logic [DW-1:0] M0_HWDATA, M1_HWDATA;
    logic          M0_HREADY, M1_HREADY;
    logic [DW-1:0] M0_HRDATA, M1_HRDATA;
    logic          M0_HRESP, M1_HRESP;
    logic          S_HSEL, S_HWRITE, S_HMASTLOCK, S_HREADY, S_HREADYOUT, S_HRESP;
    logic [AW-1:0] S_HADDR;
    logic [1:0]    S_HTRANS;
    logic [2:0]    S_HSIZE, S_HBURST;
    logic [3:0]    S_HPROT;
    logic [DW-1:0] S_HWDATA, S_HRDATA;

    int checks = 0;
    int errors = 0;

    ahb_lite_arbiter_2m #(.AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
        .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT),
        .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
        .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
        .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
        .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT),
        .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
        .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HPROT(S_HPROT),
        .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
        .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_m(input int m, input logic sel, input logic [1:0] trans,
                           input logic [31:0] addr, input logic write,
                           input logic [2:0] burst, input logic lock);
        if (m == 0) begin
            M0_HSEL = sel; M0_HTRANS = trans; M0_HADDR = addr; M0_HWRITE = write;
            M0_HSIZE = 3'b010; M0_HBURST = burst; M0_HPROT = 4'b0011; M0_HMASTLOCK = lock;
        end else begin
            M1_HSEL = sel; M1_HTRANS = trans; M1_HADDR = addr; M1_HWRITE = write;
            M1_HSIZE = 3'b010; M1_HBURST = burst; M1_HPROT = 4'b0011; M1_HMASTLOCK = lock;
        end
    endtask

    task automatic idle_masters();
        drive_m(0, 1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
        drive_m(1, 1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        idle_masters();
        M0_HWDATA = '0; M1_HWDATA = '0;
        S_HREADYOUT = 1'b1; S_HRESP = 1'b0; S_HRDATA = '0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        drive_m(0, 1'b0, 2'b00, 32'hFFFF_FFF0, 1'b1, 3'b000, 1'b0);
        drive_m(1, 1'b0, 2'b00, 32'hFFFF_FFF4, 1'b1, 3'b000, 1'b0);
        M0_HWDATA = 32'hFFFF_FFFF; M1_HWDATA = 32'hFFFF_FFFF;
        S_HREADYOUT = 1'b0; S_HRESP = 1'b1; S_HRDATA = 32'hFFFF_FFFF;
        repeat (2) @(posedge HCLK);
        #1;
        checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL rst_m0_hready: got %b expected 1", M0_HREADY); end
        checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL rst_m1_hready: got %b expected 1", M1_HREADY); end
        checks++; if (M0_HRESP !== 1'b0) begin errors++; $display("FAIL rst_m0_hresp: got %b expected 0", M0_HRESP); end
        checks++; if (M0_HRDATA !== 32'h0) begin errors++; $display("FAIL rst_m0_hrdata: got %h expected 0", M0_HRDATA); end
        checks++; if (S_HSEL !== 1'b0) begin errors++; $display("FAIL rst_s_hsel: got %b expected 0", S_HSEL); end
        checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL rst_s_htrans: got %b expected 00", S_HTRANS); end
        checks++; if (S_HADDR !== 32'h0) begin errors++; $display("FAIL rst_s_haddr: got %h expected 0", S_HADDR); end
        checks++; if (S_HWDATA !== 32'h0) begin errors++; $display("FAIL rst_s_hwdata: got %h expected 0", S_HWDATA); end
        checks++; if (S_HREADY !== 1'b1) begin errors++; $display("FAIL rst_s_hready: got %b expected 1", S_HREADY); end
        M0_HWDATA = '0; M1_HWDATA = '0;
        S_HREADYOUT = 1'b1; S_HRESP = 1'b0; S_HRDATA = '0;
        idle_masters();
        HRESET = 1'b0;
    endtask

    task automatic test_seq_busy();
        step(); drive_m(0, 1'b1, 2'b01, 32'h800, 1'b0, 3'b000, 1'b0); settle();
        step(); drive_m(0, 1'b0, 2'b10, 32'h804, 1'b0, 3'b000, 1'b0); settle();
        checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL busy_ignored: M0_HREADY got %b expected 1", M0_HREADY); end
        step(); drive_m(0, 1'b1, 2'b11, 32'h840, 1'b0, 3'b011, 1'b0); settle();
        checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL hsel0_ignored: M0_HREADY got %b expected 1", M0_HREADY); end
        checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL busy_not_fwd: S_HTRANS got %b expected 00", S_HTRANS); end
        step(); idle_masters(); settle();
        checks++; if (M0_HREADY !== 1'b0) begin errors++; $display("FAIL seq_captured: M0_HREADY got %b expected 0", M0_HREADY); end
        step(); settle();
        checks++; if (S_HTRANS !== 2'b10) begin errors++; $display("FAIL seq_as_nonseq: S_HTRANS got %b expected 10", S_HTRANS); end
        checks++; if (S_HBURST !== 3'b000) begin errors++; $display("FAIL seq_single: S_HBURST got %b expected 000", S_HBURST); end
        checks++; if (S_HADDR !== 32'h840) begin errors++; $display("FAIL seq_addr: S_HADDR got %h expected 00000840", S_HADDR); end
        step(); settle();
        checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL seq_done: M0_HREADY got %b expected 1", M0_HREADY); end
        step();
    endtask

    task automatic test_single_write();
        step(); drive_m(0, 1'b1, 2'b10, 32'h100, 1'b1, 3'b000, 1'b0); settle();
        checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL sw_accept: M0_HREADY got %b expected 1", M0_HREADY); end
        step(); idle_masters(); M0_HWDATA = 32'hA5A5_0001; settle();
        checks++; if (M0_HREADY !== 1'b0) begin errors++; $display("FAIL sw_wait1: M0_HREADY got %b expected 0", M0_HREADY); end
        checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL sw_idle: S_HTRANS got %b expected 00", S_HTRANS); end
        step(); settle();
        checks++; if (S_HTRANS !== 2'b10) begin errors++; $display("FAIL sw_htrans: S_HTRANS got %b expected 10", S_HTRANS); end
        checks++; if (S_HSEL !== 1'b1) begin errors++; $display("FAIL sw_hsel: S_HSEL got %b expected 1", S_HSEL); end
        checks++; if (S_HADDR !== 32'h100) begin errors++; $display("FAIL sw_haddr: S_HADDR got %h expected 00000100", S_HADDR); end
        checks++; if (S_HWRITE !== 1'b1) begin errors++; $display("FAIL sw_hwrite: S_HWRITE got %b expected 1", S_HWRITE); end
        checks++; if (M0_HREADY !== 1'b0) begin errors++; $display("FAIL sw_wait2: M0_HREADY got %b expected 0", M0_HREADY); end
        step(); settle();
        checks++; if (S_HWDATA !== 32'hA5A5_0001) begin errors++; $display("FAIL sw_hwdata: S_HWDATA got %h expected a5a50001", S_HWDATA); end
        checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL sw_done: M0_HREADY got %b expected 1", M0_HREADY); end
        checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL sw_data_htrans: S_HTRANS got %b expected 00", S_HTRANS); end
        step(); settle();
        checks++; if (S_HWDATA !== 32'h0) begin errors++; $display("FAIL sw_idle_hwdata: S_HWDATA got %h expected 0", S_HWDATA); end
        checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL sw_after: S_HTRANS got %b expected 00", S_HTRANS); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step();
        drive_m(0, 1'b1, 2'b10, 32'h200, 1'b1, 3'b000, 1'b0);
        drive_m(1, 1'b1, 2'b10, 32'h300, 1'b0, 3'b000, 1'b0);
        settle();
        step(); idle_masters(); M0_HWDATA = 32'h0000_0200; settle();
        checks++; if ({M0_HREADY, M1_HREADY} !== 2'b00) begin errors++; $display("FAIL sim_both_wait: HREADY got %b expected 00", {M0_HREADY, M1_HREADY}); end
        step(); settle();
        checks++; if (S_HADDR !== 32'h200) begin errors++; $display("FAIL sim_m0_first: S_HADDR got %h expected 00000200", S_HADDR); end
        step(); settle();
        checks++; if ({M0_HREADY, M1_HREADY} !== 2'b10) begin errors++; $display("FAIL sim_m0_done: HREADY got %b expected 10", {M0_HREADY, M1_HREADY}); end
        checks++; if (S_HWDATA !== 32'h200) begin errors++; $display("FAIL sim_hwdata: S_HWDATA got %h expected 00000200", S_HWDATA); end
        step(); S_HRDATA = 32'hCAFE_0003; settle();
        checks++; if (S_HTRANS !== 2'b10) begin errors++; $display("FAIL sim_b2b: S_HTRANS got %b expected 10", S_HTRANS); end
        checks++; if (S_HADDR !== 32'h300) begin errors++; $display("FAIL sim_m1_addr: S_HADDR got %h expected 00000300", S_HADDR); end
        checks++; if (M1_HRDATA !== 32'h0) begin errors++; $display("FAIL sim_rdata_addr: M1_HRDATA got %h expected 0", M1_HRDATA); end
        step(); settle();
        checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL sim_m1_done: M1_HREADY got %b expected 1", M1_HREADY); end
        checks++; if (M1_HRDATA !== 32'hCAFE_0003) begin errors++; $display("FAIL sim_m1_rdata: M1_HRDATA got %h expected cafe0003", M1_HRDATA); end
        checks++; if (M0_HRDATA !== 32'h0) begin errors++; $display("FAIL sim_m0_rdata: M0_HRDATA got %h expected 0", M0_HRDATA); end
        // M0 alone, so the next tie must go to M1
        step(); S_HRDATA = '0; drive_m(0, 1'b1, 2'b10, 32'h220, 1'b0, 3'b000, 1'b0); settle();
        step(); idle_masters(); settle();
        step(); settle();
        checks++; if (S_HADDR !== 32'h220) begin errors++; $display("FAIL rr_m0_alone: S_HADDR got %h expected 00000220", S_HADDR); end
        step(); settle();
        step();
        drive_m(0, 1'b1, 2'b10, 32'h230, 1'b0, 3'b000, 1'b0);
        drive_m(1, 1'b1, 2'b10, 32'h330, 1'b0, 3'b000, 1'b0);
        settle();
        step(); idle_masters(); settle();
        step(); settle();
        checks++; if (S_HADDR !== 32'h330) begin errors++; $display("FAIL rr_m1_wins: S_HADDR got %h expected 00000330", S_HADDR); end
        step(); settle();
        step(); settle();
        checks++; if (S_HADDR !== 32'h230 || S_HTRANS !== 2'b10) begin errors++; $display("FAIL rr_m0_next: S_HADDR/HTRANS got %h/%b expected 00000230/10", S_HADDR, S_HTRANS); end
        step(); settle();
        step();
    endtask

    task automatic test_lock();
        logic [31:0] m1_addr[4];
        logic        m1_lock[4];
        logic [31:0] exp_seq[5];
        logic [31:0] seen[$];
        int          k;
        bit          m0_sent;
        m1_addr = '{32'h400, 32'h404, 32'h408, 32'h40C};
        m1_lock = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_seq = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h500};
        k = 0;
        m0_sent = 1'b0;
        for (int cyc = 0; cyc < 80 && seen.size() < 5; cyc++) begin
            step();
            if (k < 4) drive_m(1, 1'b1, 2'b10, m1_addr[k], 1'b0, 3'b000, m1_lock[k]);
            else       drive_m(1, 1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
            if (cyc >= 1 && !m0_sent) drive_m(0, 1'b1, 2'b10, 32'h500, 1'b0, 3'b000, 1'b0);
            else                      drive_m(0, 1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0);
            settle();
            if (S_HTRANS == 2'b10) seen.push_back(S_HADDR);
            if (k < 4 && M1_HREADY) k++;
            if (cyc >= 1 && !m0_sent && M0_HREADY) m0_sent = 1'b1;
        end
        idle_masters();
        repeat (3) step();
        checks++; if (seen.size() != 5) begin errors++; $display("FAIL lock_count: forwarded %0d transfers expected 5", seen.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < seen.size()) begin
                checks++;
                if (seen[i] !== exp_seq[i]) begin errors++; $display("FAIL lock_order[%0d]: S_HADDR got %h expected %h", i, seen[i], exp_seq[i]); end
            end
        end
    endtask

    task automatic test_error();
        step(); drive_m(0, 1'b1, 2'b10, 32'h600, 1'b0, 3'b000, 1'b0); settle();
        step(); idle_masters(); settle();
        step(); settle();
        step(); S_HREADYOUT = 1'b0; S_HRESP = 1'b1; settle();
        checks++; if ({M0_HRESP, M0_HREADY} !== 2'b10) begin errors++; $display("FAIL err_first: M0 HRESP/HREADY got %b expected 10", {M0_HRESP, M0_HREADY}); end
        checks++; if ({M1_HRESP, M1_HREADY} !== 2'b01) begin errors++; $display("FAIL err_other1: M1 HRESP/HREADY got %b expected 01", {M1_HRESP, M1_HREADY}); end
        step(); S_HREADYOUT = 1'b1; S_HRESP = 1'b1; settle();
        checks++; if ({M0_HRESP, M0_HREADY} !== 2'b11) begin errors++; $display("FAIL err_second: M0 HRESP/HREADY got %b expected 11", {M0_HRESP, M0_HREADY}); end
        checks++; if (M1_HRESP !== 1'b0) begin errors++; $display("FAIL err_other2: M1_HRESP got %b expected 0", M1_HRESP); end
        step(); settle();
        checks++; if ({M0_HRESP, M0_HREADY} !== 2'b01) begin errors++; $display("FAIL err_idle_gated: M0 HRESP/HREADY got %b expected 01", {M0_HRESP, M0_HREADY}); end
        S_HRESP = 1'b0;
    endtask

    task automatic test_read_waits();
        int  waits;
        bit  done;
        waits = 0;
        done  = 1'b0;
        step(); drive_m(1, 1'b1, 2'b10, 32'h700, 1'b0, 3'b000, 1'b0); settle();
        for (int c = 0; c < 12 && !done; c++) begin
            step();
            if (c == 0) idle_masters();
            S_HREADYOUT = (c < 2 || c >= 5);
            S_HRDATA = (c >= 5) ? 32'h1234_5678 : 32'hDEAD_BEEF;
            settle();
            if (M1_HREADY) begin
                done = 1'b1;
                checks++; if (M1_HRDATA !== 32'h1234_5678) begin errors++; $display("FAIL rw_rdata: M1_HRDATA got %h expected 12345678", M1_HRDATA); end
                checks++; if (M0_HRDATA !== 32'h0) begin errors++; $display("FAIL rw_other_rdata: M0_HRDATA got %h expected 0", M0_HRDATA); end
            end else begin
                waits++;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL rw_timeout: M1_HREADY got 0 expected 1 within 12 cycles"); end
        checks++; if (waits != 5) begin errors++; $display("FAIL rw_waits: wait cycles got %0d expected 5", waits); end
        step(); S_HREADYOUT = 1'b1; S_HRDATA = '0;
    endtask

    task automatic test_reset_mid();
        int fwd;
        fwd = 0;
        step();
        drive_m(0, 1'b1, 2'b10, 32'h900, 1'b1, 3'b000, 1'b0);
        drive_m(1, 1'b1, 2'b10, 32'h980, 1'b0, 3'b000, 1'b0);
        settle();
        step(); idle_masters(); M0_HWDATA = 32'h0000_0099; settle();
        step(); settle();
        step(); S_HREADYOUT = 1'b0; settle();
        checks++; if ({M0_HREADY, M1_HREADY, S_HREADY} !== 3'b000) begin errors++; $display("FAIL rm_stalled: M0/M1/S HREADY got %b expected 000", {M0_HREADY, M1_HREADY, S_HREADY}); end
        #2 HRESET = 1'b1;
        #1;
        checks++; if ({S_HSEL, S_HTRANS} !== 3'b000) begin errors++; $display("FAIL rm_slave_idle: S_HSEL/HTRANS got %b expected 000", {S_HSEL, S_HTRANS}); end
        checks++; if ({M0_HREADY, M1_HREADY} !== 2'b11) begin errors++; $display("FAIL rm_hready: M0/M1 HREADY got %b expected 11", {M0_HREADY, M1_HREADY}); end
        checks++; if (S_HREADY !== 1'b1) begin errors++; $display("FAIL rm_s_hready: S_HREADY got %b expected 1", S_HREADY); end
        checks++; if (S_HWDATA !== 32'h0) begin errors++; $display("FAIL rm_hwdata: S_HWDATA got %h expected 0", S_HWDATA); end
        step(); HRESET = 1'b0; S_HREADYOUT = 1'b1; M0_HWDATA = '0;
        for (int c = 0; c < 6; c++) begin
            step(); settle();
            if (S_HTRANS !== 2'b00 || M0_HREADY !== 1'b1 || M1_HREADY !== 1'b1) fwd++;
        end
        checks++; if (fwd != 0) begin errors++; $display("FAIL rm_no_retry: activity cycles got %0d expected 0", fwd); end
    endtask

    initial begin
        test_reset();
        test_seq_busy();
        test_single_write();
        test_simultaneous();
        test_lock();
        test_error();
        test_read_waits();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_arbiter_2m.md
# ahb_lite_arbiter_2m

Two-master AHB-Lite arbiter that shares one AHB-Lite slave port (the SDRAM controller `ahb_lite_sdram`) between two requesters.
- Each master's address phase is captured into a per-master pending register.
- Pending transfers are granted round-robin, with HMASTLOCK honoured.
- Each granted transfer is replayed to the slave as a single NONSEQ transfer.
- The non-owning master is held in wait states until its transfer completes.

## Interface
- AW, 32, address width
- DW, 32, data width
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  asynchronous, active-high reset
- M0_/M1_HSEL  in  1  master slave-select
- M0_/M1_HADDR  in  AW  master address
- M0_/M1_HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- M0_/M1_HWRITE  in  1  write
- M0_/M1_HSIZE  in  3  size
- M0_/M1_HBURST  in  3  burst (not forwarded)
- M0_/M1_HPROT  in  4  protection
- M0_/M1_HMASTLOCK  in  1  locked sequence
- M0_/M1_HWDATA  in  DW  write data
- M0_/M1_HREADY  out  1  transfer done / master may advance
- M0_/M1_HRDATA  out  DW  read data
- M0_/M1_HRESP  out  1  0=OKAY, 1=ERROR
- S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK, S_HWDATA  out  as above  slave request
- S_HREADY  out  1  HREADY fed to slave
- S_HREADYOUT  in  1  slave ready
- S_HRDATA  in  DW  slave read data
- S_HRESP  in  1  slave response

## Operation
- **Capture.** On an edge where Mx_HSEL=1, Mx_HTRANS[1]=1 and Mx_HREADY=1:
  - latch HADDR/HWRITE/HSIZE/HPROT/HMASTLOCK into pend_x;
  - set pend_x_v=1.
- **Master wait states.** Mx_HREADY is 0 while pend_x_v=1, except in the completion cycle. When pend_x_v=0, Mx_HREADY=1 and Mx_HRESP=0.
- **FSM states.**
  - IDLE: grant if any pend_v. Tie goes to the master ≠ last_grant; a locked owner has exclusive eligibility. Next state ADDR.
  - ADDR: one cycle. S_HSEL=1, S_HTRANS=NONSEQ (10), S_HBURST=SINGLE (000), other controls from pend_owner. Next state DATA.
  - DATA: S_HWDATA = owner's live HWDATA (the master holds it stable in wait states). Ends on a cycle with S_HREADYOUT=1, which is the completion cycle:
    - Mx_HREADY=1 for the owner;
    - pend_owner_v cleared;
    - next state ADDR if another eligible pend exists, else IDLE.
- **Response passthrough.** In DATA, owner's HRDATA=S_HRDATA and HRESP=S_HRESP, combinationally. A two-cycle ERROR response passes through unchanged.
- **Idle outputs.** Outside DATA, Mx_HRDATA=0. In IDLE, S_HSEL=0, S_HTRANS=IDLE (00), S_HWDATA=0. S_HREADY = 1 in IDLE, otherwise S_HREADYOUT.
- **Lock.** Completing a transfer with captured HMASTLOCK=1 sets lock_owner. While locked, the other master's pend is ignored. Lock clears when the owner completes a transfer with HMASTLOCK=0.
- **last_grant** updates at each ADDR entry.
- **Simultaneous events.** Capture by the completing master at its completion edge is legal. That new pend is not eligible until the following FSM decision.
- **Unforwarded traffic.** Masters' SEQ beats become NONSEQ SINGLE; BUSY/IDLE are never forwarded.

## Timing
- **Reset values.** State=IDLE; pend_v=0, pend regs=0; lock clear; last_grant=M1, so M0 wins the first tie. Mx_HREADY=1, Mx_HRESP=0, Mx_HRDATA=0, S_HSEL=0, S_HTRANS=00, S_HADDR=0, S_HWDATA=0, S_HREADY=1.
- **Latency**, master address accepted at edge E0:
  - E0–E1: pend visible, FSM in IDLE;
  - E1–E2: ADDR;
  - E2–E3: DATA.
  - With a zero-wait slave, completion comes in the third data-phase cycle (2 inserted waits). Each slave wait adds one.
- **Back-to-back arbitration.** Going DATA→ADDR directly costs no idle cycle between masters.
- **Reset mid-transfer.** Asserting HRESET at any time returns all registers to reset values immediately. The aborted transfer is not retried.

## Test plan
- Single write: M0 writes 0xA5A5_0001 to 0x100 with zero-wait slave -> S_HTRANS=10 one cycle after capture, S_HWDATA=0xA5A5_0001, M0_HREADY low 2 cycles then high.
- Simultaneous NONSEQ from M0 and M1 after reset -> M0 served first, M1 ADDR immediately after M0 completion, last_grant=M1.
- Locked sequence: M1 issues 3 transfers with HMASTLOCK=1, then 1 with 0, while M0 requests continuously -> all 4 M1 transfers precede M0's.
- Slave ERROR: S_HRESP=1/S_HREADYOUT=0 then 1/1 -> owner sees HRESP=1 with HREADY 0 then 1; the other master sees HRESP=0.
- Read with 3 slave wait states -> owner HRDATA = S_HRDATA (0x1234_5678) in the completion cycle, total 5 master wait cycles.
- HRESET pulse during DATA -> S_HTRANS=00, both HREADY=1, both pend_v=0 in the same cycle.
